// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    // Controller states; encoding is fixed so debug probes read consistently.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the bit counter. It must hold the values 0..width-1.
    function automatic int cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// One-bit full adder. Purely combinational; the serial datapath reuses it every cycle.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum and majority carry.
    always_comb begin
        s    = x ^ y ^ cin;
        cout = (x & y) | (x & cin) | (y & cin);
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor.
// Operands are latched on start and consumed LSB first, one bit pair per clock,
// through a single full-adder cell with a registered carry. A - B is formed as
// A + ~B + 1 by inverting B at load time and presetting the carry to 1.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MSB  = CNT_W'(WIDTH - 2);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic             c_msb;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_c;

    // The single shared full-adder cell works on the current LSBs.
    fa_cell u_fa (
        .x    (op_a[0]),
        .y    (op_b[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    // Controller, operand shifters, carry flop and registered outputs.
    // NOTE: every register here updates with <= so all of them see the
    // pre-edge values of each other, just like the flops they describe.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            carry    <= 1'b0;
            c_msb    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b ^ {WIDTH{sub}};
                        carry <= sub;
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    op_a   <= op_a >> 1;
                    op_b   <= op_b >> 1;
                    result <= {fa_s, result[WIDTH-1:1]};
                    carry  <= fa_c;
                    // The carry leaving bit WIDTH-2 is the carry into the MSB.
                    if (cnt == CNT_MSB) begin
                        c_msb <= fa_c;
                    end
                    if (cnt == CNT_LAST) begin
                        cout     <= fa_c;
                        overflow <= c_msb ^ fa_c;
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed cases plus random operands
// compared against a plain-arithmetic reference model.
module tb_serial_addsub;

    localparam int WIDTH = 4;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic             CLOCK_50;
    logic             resetn;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    int check_cnt = 0;
    int pass_cnt  = 0;

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Reference: modular unsigned sum for result/carry, true signed range test for overflow.
    task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic ms,
                         output logic [WIDTH-1:0] r, output logic co, output logic ov);
        int ua, ub, full, sa, sb, sr;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (ms) begin
            full = ua + ((~ub) & MASK) + 1;
            sr   = sa - sb;
        end else begin
            full = ua + ub;
            sr   = sa + sb;
        end
        r  = WIDTH'(full & MASK);
        co = ((full >> WIDTH) & 1) != 0;
        ov = (sr > (MASK >> 1)) || (sr < -((MASK >> 1) + 1));
    endtask

    // Present a request for one cycle; returns just after the accepting edge.
    task automatic start_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic is);
        @(negedge CLOCK_50);
        a = ia; b = ib; sub = is; start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
    endtask

    // Wait for done, bounded; n counts edges after the accepting edge.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(negedge CLOCK_50);
            n++;
        end
    endtask

    task automatic check_result(input string tag, input logic [WIDTH-1:0] ia,
                                input logic [WIDTH-1:0] ib, input logic is, input int n);
        logic [WIDTH-1:0] er;
        logic eco, eov;
        model(ia, ib, is, er, eco, eov);
        check({tag, ".latency"}, n, WIDTH);
        check({tag, ".done"}, done, 1'b1);
        check({tag, ".busy_done"}, busy, 1'b0);
        check({tag, ".result"}, result, er);
        check({tag, ".cout"}, cout, eco);
        check({tag, ".overflow"}, overflow, eov);
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] ia,
                          input logic [WIDTH-1:0] ib, input logic is);
        int n;
        start_op(ia, ib, is);
        check({tag, ".busy"}, busy, 1'b1);
        wait_done(n);
        check_result(tag, ia, ib, is, n);
        @(negedge CLOCK_50);
        check({tag, ".pulse"}, done, 1'b0);
    endtask

    initial begin
        int n;
        int dones;
        logic [WIDTH-1:0] ra, rb;
        logic rs;

        resetn = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge CLOCK_50);
        resetn = 1'b1;
        @(negedge CLOCK_50);
        check("rst.busy", busy, 1'b0);
        check("rst.done", done, 1'b0);
        check("rst.result", result, '0);
        check("rst.cout", cout, 1'b0);
        check("rst.overflow", overflow, 1'b0);
        dones = 0;
        repeat (10) begin
            @(negedge CLOCK_50);
            if (done) dones++;
        end
        check("idle.no_done", dones, 0);

        // Directed arithmetic cases.
        run_op("add_ovf",  4'b0101, 4'b0011, 1'b0);
        check("add_ovf.abs", result, 4'b1000);
        run_op("sub_neg",  4'b0011, 4'b0101, 1'b1);
        check("sub_neg.abs", result, 4'b1110);
        run_op("sub_zero", 4'b0111, 4'b0111, 1'b1);
        check("sub_zero.cout_abs", cout, 1'b1);
        run_op("add_wrap", 4'b1111, 4'b0001, 1'b0);
        run_op("sub_ovf",  4'b1000, 4'b0001, 1'b1);
        check("sub_ovf.abs", {result, overflow}, {4'b0111, 1'b1});

        // Start during RUN is ignored; start in the DONE cycle chains immediately.
        start_op(4'b0001, 4'b0001, 1'b0);
        @(negedge CLOCK_50);
        a = 4'b1111; start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        n = 2;
        while (!done && n < 40) begin
            @(negedge CLOCK_50);
            n++;
        end
        check_result("busy_ign", 4'b0001, 4'b0001, 1'b0, n);
        check("busy_ign.abs", result, 4'b0010);
        a = 4'b0010; b = 4'b0010; sub = 1'b0; start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        check("b2b.busy", busy, 1'b1);
        check("b2b.nodone", done, 1'b0);
        wait_done(n);
        check_result("b2b", 4'b0010, 4'b0010, 1'b0, n);
        check("b2b.abs", result, 4'b0100);
        @(negedge CLOCK_50);

        // Random operands against the model.
        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom_range(0, MASK));
            rb = WIDTH'($urandom_range(0, MASK));
            rs = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d", i), ra, rb, rs);
        end

        // Leave nonzero flags behind, then abort an operation with reset.
        run_op("pre_abort", 4'b0111, 4'b0001, 1'b0);
        start_op(4'b0110, 4'b0011, 1'b0);
        @(negedge CLOCK_50);
        resetn = 1'b0;
        #1;
        check("abort.busy", busy, 1'b0);
        check("abort.done", done, 1'b0);
        check("abort.result", result, '0);
        check("abort.cout", cout, 1'b0);
        check("abort.overflow", overflow, 1'b0);
        dones = 0;
        repeat (3) begin
            @(negedge CLOCK_50);
            if (done) dones++;
        end
        resetn = 1'b1;
        repeat (6) begin
            @(negedge CLOCK_50);
            if (done || busy) dones++;
        end
        check("abort.no_done", dones, 0);
        run_op("after_abort", 4'b0110, 4'b0011, 1'b0);
        check("after_abort.abs", {result, overflow}, {4'b1001, 1'b1});

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial two's-complement adder/subtractor.
- Latches two WIDTH-bit operands on a start pulse, then feeds one bit pair per clock, LSB first, through a single full-adder cell with a registered carry.
- Shifts each sum bit into a result register and raises a one-cycle done pulse when finished.
- Sits in the arithmetic datapath as the sequential, area-minimal alternative to the ripple adder-subtractor, driven by the switch/key front end and read by the LED display stage.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..16).

Ports:
- CLOCK_50  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE and DONE.
- sub  input  1  operation select, sampled with start: 0 = A+B, 1 = A-B.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  sum or difference; holds its value until the next accepted start.
- cout  output  1  final carry out (for sub, 1 = no borrow).
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: resetn low forces IDLE immediately (asynchronous). Shift registers, carry, bit counter, result, cout, overflow, busy and done all go to 0.
- Reset mid-operation aborts the operation with no done pulse. After release the block waits in IDLE for a new start.
- FSM states: IDLE, RUN, DONE.
- IDLE: on start=1, accept the request:
  - opA <= a; opB <= b XOR {WIDTH{sub}}; carry <= sub; cnt <= 0.
  - Next state RUN.
- RUN: each cycle, a full-adder cell computes s = opA[0] ^ opB[0] ^ carry and c = majority(opA[0], opB[0], carry).
  - opA and opB shift right by one.
  - Result register shifts right with s entering at the MSB.
  - carry <= c; cnt <= cnt+1.
  - On the cycle cnt = WIDTH-2, capture the current carry as the carry into the MSB (c_msb).
  - When cnt = WIDTH-1, the state after the clock edge is DONE. At that edge: cout <= c; overflow <= c_msb ^ c.
- DONE: lasts exactly one cycle with done=1.
  - If start=1 in this cycle, the request is accepted exactly as in IDLE and the next state is RUN (back-to-back operation).
  - Otherwise the next state is IDLE.
- busy = (state == RUN), registered-equivalent with no glitch paths to outputs.
- Latency: start sampled at edge 0 → RUN occupies edges 1..WIDTH → done high in the cycle after edge WIDTH. Total WIDTH+1 cycles from the start edge to done.
- Throughput with back-to-back starts: one result per WIDTH+1 cycles.
- start while in RUN is ignored. No queueing; a, b and sub are not re-sampled.
- result, cout and overflow are stable from done until the next accepted start.
  - During RUN, result shows partial shifting contents; consumers must qualify with done or !busy.
- Width rules:
  - cnt is clog2(WIDTH) bits wide and never wraps past WIDTH-1.
  - Results are modulo 2^WIDTH; no internal sign extension.

Decomposition:
- Shared package serial_addsub_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - localparam CNT_W = clog2(WIDTH)
- One sub-module: fa_cell, a purely combinational 1-bit full adder (x, y, cin → s, cout), instantiated once in the datapath.
- FSM, shift registers and carry flop live in serial_addsub.

Test Plan:
- Reset then idle: hold resetn=0 for 3 cycles, release → busy=0, done=0, result=0000, cout=0, overflow=0; no done without start.
- Add with signed overflow: a=0101, b=0011, sub=0, start 1 cycle → busy for 4 cycles; done at cycle 5 with result=1000, cout=0, overflow=1.
- Subtract to negative: a=0011, b=0101, sub=1 → result=1110, cout=0, overflow=0. Then a=0111, b=0111, sub=1 → result=0000, cout=1, overflow=0.
- Unsigned wrap: a=1111, b=0001, sub=0 → result=0000, cout=1, overflow=0. Also a=1000, b=0001, sub=1 → result=0111, overflow=1.
- Start while busy: start a=0001 b=0001 add; pulse start with a=1111 during RUN → single done, result=0010. Start asserted in the DONE cycle with a=0010 b=0010 → immediate RUN; second done 5 cycles later with result=0100.
- Reset mid-op: start a=0110 b=0011 add, drop resetn after 2 RUN cycles → all outputs 0 immediately, no done. A fresh start after release gives the correct result=1001, overflow=1.
